// File: rtl/reg_arb_pkg.sv
// Shared types for the register access arbiter.
//   state_e : access FSM states
//   PORT_A / PORT_B : port-select encoding used by the arbiter and datapath
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Two-port register access bus (port A = SPI side, port B = local logic).
//   *_req/*_we/*_addr/*_wdata : requester -> arbiter
//   *_gnt/*_rvalid/*_rdata    : arbiter -> requester
// master = requesters, slave = arbiter.
interface reg_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned REG_WIDTH  = 8
) ();

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [REG_WIDTH-1:0]  a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [REG_WIDTH-1:0]  a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [REG_WIDTH-1:0]  b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [REG_WIDTH-1:0]  b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin selector.
//   a_req, b_req : requests
//   take         : the current selection is being granted (updates pointer)
//   sel_c        : combinational winner (PORT_A / PORT_B)
// The only state is the last-granted pointer; reset makes A the favourite.
module rr_arbiter_2
  import reg_arb_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic a_req,
  input  logic b_req,
  input  logic take,
  output logic sel_c
);

  logic last_q;
  logic last_d;

  // Winner: lone requester wins; on a tie, the port not granted last wins.
  always_comb begin
    sel_c = PORT_A;
    if (a_req && b_req) begin
      sel_c = (last_q == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      sel_c = PORT_B;
    end
  end

  always_comb begin
    last_d = last_q;
    if (take) begin
      last_d = sel_c;
    end
  end

  // Reset value B means "A was granted least recently".
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= PORT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Two-port register bank arbiter: config (R/W) and status (RO) registers.
//   clk, rstb   : clock, async active-low reset
//   ena         : global enable; everything holds and strobes are masked while low
//   bus         : port A / port B request, grant, completion and read data
//   err         : one-cycle pulse on an out-of-range access (DONE cycle)
//   config_regs : flat config bank, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   status_regs : flat status bank, same packing
// One access takes IDLE -> ACCESS (gnt) -> DONE (rvalid).
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_CFG    = 4,
  parameter int unsigned NUM_STATUS = 4,
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  reg_access_arbiter_if.slave             bus,
  output logic                            err,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int unsigned NUM_REGS = NUM_CFG + NUM_STATUS;

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]  cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0]  cfg_d [NUM_CFG];
  logic [REG_WIDTH-1:0]  a_rdata_q, a_rdata_d;
  logic [REG_WIDTH-1:0]  b_rdata_q, b_rdata_d;
  logic                  gnt_q, gnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic                  take_c;
  logic                  arb_sel_c;
  logic [31:0]           addr_ext_c;
  logic                  oor_c;
  logic [REG_WIDTH-1:0]  rd_val_c;

  assign take_c = ena && (state_q == IDLE) && (bus.a_req || bus.b_req);

  rr_arbiter_2 u_rr (
    .clk   (clk),
    .rstb  (rstb),
    .a_req (bus.a_req),
    .b_req (bus.b_req),
    .take  (take_c),
    .sel_c (arb_sel_c)
  );

  // Address decode and read mux; writes and out-of-range reads return 0.
  always_comb begin
    addr_ext_c = 32'(addr_q);
    oor_c      = (addr_ext_c >= NUM_REGS);
    rd_val_c   = '0;
    if (!we_q) begin
      for (int i = 0; i < int'(NUM_CFG); i++) begin
        if (addr_ext_c == 32'(i)) rd_val_c = cfg_q[i];
      end
      for (int j = 0; j < int'(NUM_STATUS); j++) begin
        if (addr_ext_c == NUM_CFG + 32'(j)) rd_val_c = status_regs[j*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // FSM next state and datapath; nothing advances while ena is low.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cfg_d     = cfg_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    gnt_d     = gnt_q;
    rvalid_d  = rvalid_q;
    err_d     = err_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (take_c) begin
            sel_d   = arb_sel_c;
            we_d    = (arb_sel_c == PORT_B) ? bus.b_we    : bus.a_we;
            addr_d  = (arb_sel_c == PORT_B) ? bus.b_addr  : bus.a_addr;
            wdata_d = (arb_sel_c == PORT_B) ? bus.b_wdata : bus.a_wdata;
            gnt_d   = 1'b1;
            state_d = ACCESS;
          end
        end
        ACCESS: begin
          gnt_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = oor_c;
          // Only config addresses accept writes; status/out-of-range are dropped.
          if (we_q) begin
            for (int i = 0; i < int'(NUM_CFG); i++) begin
              if (addr_ext_c == 32'(i)) cfg_d[i] = wdata_q;
            end
          end
          if (sel_q == PORT_A) a_rdata_d = rd_val_c;
          else                 b_rdata_d = rd_val_c;
          state_d = DONE;
        end
        DONE: begin
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
        default: begin
          gnt_d    = 1'b0;
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      sel_q     <= PORT_A;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cfg_q     <= '{default: '0};
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      gnt_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cfg_q     <= cfg_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Strobe flags stay set while the FSM is held, so masking with ena
  // releases each pulse exactly once when ena returns.
  assign bus.a_gnt    = ena && gnt_q    && (sel_q == PORT_A);
  assign bus.b_gnt    = ena && gnt_q    && (sel_q == PORT_B);
  assign bus.a_rvalid = ena && rvalid_q && (sel_q == PORT_A);
  assign bus.b_rvalid = ena && rvalid_q && (sel_q == PORT_B);
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign err          = ena && err_q;

  for (genvar g = 0; g < int'(NUM_CFG); g++) begin : g_cfg_flat
    assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: directed accesses push expected
// grants/completions into queues; a negedge monitor pops and compares.
module tb_reg_access_arbiter;
  import reg_arb_pkg::*;

  localparam int unsigned NUM_CFG    = 4;
  localparam int unsigned NUM_STATUS = 4;
  localparam int unsigned REG_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic        err;
  logic [31:0] config_regs;
  logic [31:0] status_regs;

  reg_access_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .REG_WIDTH(REG_WIDTH)) bus ();

  reg_access_arbiter #(
    .NUM_CFG(NUM_CFG), .NUM_STATUS(NUM_STATUS),
    .REG_WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .bus(bus), .err(err),
    .config_regs(config_regs), .status_regs(status_regs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t rv_q[$];
  logic gnt_exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every strobe must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    logic p;
    if (rstb) begin
      if (bus.a_gnt || bus.b_gnt) begin
        chk("gnt_exclusive", 32'(bus.a_gnt & bus.b_gnt), 32'd0);
        if (gnt_exp_q.size() == 0) fail_msg("unexpected_gnt");
        else begin
          p = gnt_exp_q.pop_front();
          chk("gnt_port", 32'(bus.b_gnt), 32'(p));
        end
      end
      if (bus.a_rvalid || bus.b_rvalid) begin
        chk("rvalid_exclusive", 32'(bus.a_rvalid & bus.b_rvalid), 32'd0);
        if (rv_q.size() == 0) fail_msg("unexpected_rvalid");
        else begin
          e = rv_q.pop_front();
          chk("rvalid_port", 32'(bus.b_rvalid), 32'(e.port));
          chk("rdata", 32'(bus.b_rvalid ? bus.b_rdata : bus.a_rdata), 32'(e.rdata));
          chk("err", 32'(err), 32'(e.err));
        end
      end else if (err) begin
        fail_msg("err_without_rvalid");
      end
    end
  end

  task automatic set_req(input logic port, input logic we, input logic [3:0] addr,
                         input logic [7:0] wd);
    if (port == PORT_B) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  task automatic clr_req(input logic port);
    if (port == PORT_B) bus.b_req = 1'b0;
    else                bus.a_req = 1'b0;
  endtask

  // Waits (bounded) at negedges for the given port's grant.
  task automatic wait_gnt(input logic port);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (port == PORT_B ? bus.b_gnt : bus.a_gnt) seen = 1'b1;
    end
    chk("gnt_seen", 32'(seen), 32'd1);
  endtask

  // Waits (bounded) for the scoreboard to empty, then aligns to posedge+1.
  task automatic drain();
    for (int k = 0; k < 40 && (rv_q.size() != 0 || gnt_exp_q.size() != 0); k++) @(negedge clk);
    chk("drained", 32'(rv_q.size() + gnt_exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic port, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err);
    gnt_exp_q.push_back(port);
    rv_q.push_back('{port: port, rdata: exp_rd, err: exp_err});
    set_req(port, we, addr, wd);
    wait_gnt(port);
    clr_req(port);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int rel;
    int t;
    rstb = 1'b0;
    ena  = 1'b1;
    status_regs = 32'h55AA10CA;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Both ports request from reset: grants A,B,A,B three cycles apart.
    set_req(PORT_A, 1'b0, 4'd4, 8'h00);
    set_req(PORT_B, 1'b0, 4'd7, 8'h00);
    for (int k = 0; k < 2; k++) begin
      gnt_exp_q.push_back(PORT_A);
      gnt_exp_q.push_back(PORT_B);
      rv_q.push_back('{port: PORT_A, rdata: 8'hCA, err: 1'b0});
      rv_q.push_back('{port: PORT_B, rdata: 8'h55, err: 1'b0});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_config", config_regs, 32'd0);
    chk("rst_a_rdata", 32'(bus.a_rdata), 32'd0);
    chk("rst_b_rdata", 32'(bus.b_rdata), 32'd0);
    chk("rst_strobes", 32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, err}), 32'd0);
    @(posedge clk);
    #1 rstb = 1'b1;
    rel = cyc;
    wait_gnt(PORT_A);
    chk("first_gnt_not_early", 32'((cyc - rel) >= 1), 32'd1);
    t = cyc;
    wait_gnt(PORT_B);  chk("gnt_spacing_1", 32'(cyc - t), 32'd3); t = cyc;
    wait_gnt(PORT_A);  chk("gnt_spacing_2", 32'(cyc - t), 32'd3); t = cyc;
    wait_gnt(PORT_B);  chk("gnt_spacing_3", 32'(cyc - t), 32'd3);
    clr_req(PORT_A);
    clr_req(PORT_B);
    drain();

    // Config write then read back.
    access(PORT_A, 1'b1, 4'd1, 8'h5A, 8'h00, 1'b0);
    access(PORT_A, 1'b0, 4'd1, 8'h00, 8'h5A, 1'b0);
    chk("cfg1_byte", 32'(config_regs[15:8]), 32'h5A);
    chk("cfg_bank_1", config_regs, 32'h00005A00);

    // Status reads.
    access(PORT_B, 1'b0, 4'd4, 8'h00, 8'hCA, 1'b0);
    access(PORT_B, 1'b0, 4'd7, 8'h00, 8'h55, 1'b0);

    // Status write is ignored, no err.
    access(PORT_A, 1'b1, 4'd5, 8'hFF, 8'h00, 1'b0);
    access(PORT_A, 1'b0, 4'd5, 8'h00, 8'h10, 1'b0);
    chk("cfg_bank_2", config_regs, 32'h00005A00);

    // Cross-port config traffic, boundary addresses 0 and 3.
    access(PORT_A, 1'b1, 4'd0, 8'h3C, 8'h00, 1'b0);
    access(PORT_B, 1'b0, 4'd0, 8'h00, 8'h3C, 1'b0);
    access(PORT_B, 1'b1, 4'd3, 8'h81, 8'h00, 1'b0);
    access(PORT_A, 1'b0, 4'd3, 8'h00, 8'h81, 1'b0);
    chk("cfg_bank_3", config_regs, 32'h81005A3C);

    // Out-of-range read and write: err, rdata 0, bank untouched.
    access(PORT_A, 1'b0, 4'd9,  8'h00, 8'h00, 1'b1);
    access(PORT_B, 1'b1, 4'd12, 8'hEE, 8'h00, 1'b1);
    chk("cfg_bank_4", config_regs, 32'h81005A3C);

    // ena low for 5 cycles starting in ACCESS: strobes masked, then one gnt.
    gnt_exp_q.push_back(PORT_A);
    rv_q.push_back('{port: PORT_A, rdata: 8'h5A, err: 1'b0});
    set_req(PORT_A, 1'b0, 4'd1, 8'h00);
    @(posedge clk);
    #1 ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ena_low_quiet", 32'({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, err}), 32'd0);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    wait_gnt(PORT_A);
    clr_req(PORT_A);
    drain();

    // Reset during the ACCESS of a write: write lost, no rvalid afterwards.
    gnt_exp_q.push_back(PORT_A);
    set_req(PORT_A, 1'b1, 4'd2, 8'h33);
    wait_gnt(PORT_A);
    clr_req(PORT_A);
    #1 rstb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_config", config_regs, 32'd0);
    chk("abort_a_rdata", 32'(bus.a_rdata), 32'd0);
    @(posedge clk);
    #1 rstb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
    end
    chk("abort_queue_empty", 32'(gnt_exp_q.size() + rv_q.size()), 32'd0);

    // Simultaneous requests after reset: A first again, then B.
    @(posedge clk);
    #1;
    gnt_exp_q.push_back(PORT_A);
    gnt_exp_q.push_back(PORT_B);
    rv_q.push_back('{port: PORT_A, rdata: 8'h00, err: 1'b0});
    rv_q.push_back('{port: PORT_B, rdata: 8'hAA, err: 1'b0});
    set_req(PORT_A, 1'b0, 4'd2, 8'h00);
    set_req(PORT_B, 1'b0, 4'd6, 8'h00);
    wait_gnt(PORT_A);
    clr_req(PORT_A);
    wait_gnt(PORT_B);
    clr_req(PORT_B);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
